// File: rtl/jump_predecode_if.sv
// Fetch -> predecode -> decode bundle, plus the RAS and fetch-redirect side channels.
// No storage of its own; all timing is set by the predecoder stage.
// Backpressure: if_ready/id_ready are plain valid-ready handshakes.
interface jump_predecode_if #(
  parameter int WIDTH = 64
);
  // fetch side
  logic             if_valid;
  logic             if_ready;
  logic [WIDTH-1:0] if_pc;
  logic [31:0]      if_instr;
  // return address stack side
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] ras_addr;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  // fetch redirect
  logic             redir_valid;
  logic [WIDTH-1:0] redir_pc;
  // decode side
  logic             id_valid;
  logic             id_ready;
  logic [WIDTH-1:0] id_pc;
  logic [31:0]      id_instr;
  logic             id_pred_taken;
  logic [WIDTH-1:0] id_pred_pc;

  // predecoder view
  modport slave (
    input  if_valid, if_pc, if_instr, ras_top, ras_empty, id_ready,
    output if_ready, ras_push, ras_pop, ras_addr, redir_valid, redir_pc,
           id_valid, id_pc, id_instr, id_pred_taken, id_pred_pc
  );

  // environment view (fetch, RAS and decode together)
  modport master (
    output if_valid, if_pc, if_instr, ras_top, ras_empty, id_ready,
    input  if_ready, ras_push, ras_pop, ras_addr, redir_valid, redir_pc,
           id_valid, id_pc, id_instr, id_pred_taken, id_pred_pc
  );
endinterface

// File: rtl/jump_predecode.sv
// Jump predecoder: classifies JAL/call/return, drives the RAS, redirects fetch and drains the wrong path.
// Latency: one cycle fetch->id; redirect pulse in the cycle after a taken fire.
// Backpressure: if_ready follows id_ready, except wrong-path beats in DRAIN are always swallowed.
// Optional statistics counters are compiled in with PREDECODE_STAT_EN.
module jump_predecode #(
  parameter int WIDTH  = 64,
  parameter int STAT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  jump_predecode_if.slave   bus_if
`ifdef PREDECODE_STAT_EN
  ,
  output logic [STAT_W-1:0] stat_call_o,
  output logic [STAT_W-1:0] stat_ret_o,
  output logic [STAT_W-1:0] stat_ret_miss_o,
  output logic [STAT_W-1:0] stat_drop_o
`endif
);

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;

  logic             id_valid_q;
  logic [WIDTH-1:0] id_pc_q;
  logic [31:0]      id_instr_q;
  logic             id_pred_taken_q;
  logic [WIDTH-1:0] id_pred_pc_q;
  logic             redir_valid_q;
  logic [WIDTH-1:0] redir_pc_q;

  // ---------------------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------------------
  logic [31:0]      instr;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [2:0]       funct3;
  logic             rd_link;
  logic             rs1_link;
  logic             is_jal;
  logic             is_jalr;
  logic             is_call;
  logic             is_ret;
  logic [20:0]      jal_off;
  logic [WIDTH-1:0] jal_tgt;
  logic             pred_taken;
  logic [WIDTH-1:0] pred_pc;

  assign instr    = bus_if.if_instr;
  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign is_jal   = (opcode == OPC_JAL);
  assign is_jalr  = (opcode == OPC_JALR) && (funct3 == 3'b000);

  // A JALR that links is always treated as a call, even when rs1 is also a
  // link register (co-routine swap): push only, target unknown here.
  assign is_call  = (is_jal && rd_link) || (is_jalr && rd_link);
  assign is_ret   = is_jalr && !rd_link && rs1_link;

  // J-type immediate, sign-extended; the add wraps mod 2^WIDTH.
  assign jal_off  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign jal_tgt  = bus_if.if_pc + {{(WIDTH-21){jal_off[20]}}, jal_off};

  // A return with an empty RAS has no usable target, so it stays not-taken.
  assign pred_taken = is_jal || (is_ret && !bus_if.ras_empty);
  assign pred_pc    = is_jal ? jal_tgt : bus_if.ras_top;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic kill;
  logic drain_miss;
  logic fire;
  logic discard;

  // Reset and flush both block the stage for the cycle they are asserted.
  assign kill       = rst_i || flush_i;
  assign drain_miss = (state_q == ST_DRAIN) && (bus_if.if_pc != target_q);

  // Wrong-path beats never need the decode slot, so they are taken regardless.
  assign bus_if.if_ready = !kill && (drain_miss || !id_valid_q || bus_if.id_ready);

  assign fire    = bus_if.if_valid && bus_if.if_ready && !drain_miss;
  assign discard = bus_if.if_valid && !kill && drain_miss;

  // RAS requests are only meaningful for a beat that actually moves into the stage.
  assign bus_if.ras_push = fire && is_call;
  assign bus_if.ras_pop  = fire && is_ret && !bus_if.ras_empty;
  assign bus_if.ras_addr = fire ? bus_if.if_pc : '0;

  // ---------------------------------------------------------------------------
  // Redirect / drain FSM
  // ---------------------------------------------------------------------------

  // Next-state: a taken fire arms DRAIN on its target; any other fire returns to RUN.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (flush_i) begin
      state_d = ST_RUN;
    end else if (fire) begin
      if (pred_taken) begin
        state_d  = ST_DRAIN;
        target_d = pred_pc;
      end else begin
        state_d  = ST_RUN;
      end
    end
  end

  // FSM state and drain target registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------

  // Decode-side pipeline register; holds while decode stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_valid_q      <= 1'b0;
      id_pc_q         <= '0;
      id_instr_q      <= '0;
      id_pred_taken_q <= 1'b0;
      id_pred_pc_q    <= '0;
    end else if (flush_i) begin
      id_valid_q      <= 1'b0;
    end else if (fire) begin
      id_valid_q      <= 1'b1;
      id_pc_q         <= bus_if.if_pc;
      id_instr_q      <= instr;
      id_pred_taken_q <= pred_taken;
      id_pred_pc_q    <= pred_taken ? pred_pc : '0;
    end else if (bus_if.id_ready) begin
      id_valid_q      <= 1'b0;
    end
  end

  // One-cycle redirect pulse following each taken fire.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else if (flush_i) begin
      redir_valid_q <= 1'b0;
    end else begin
      redir_valid_q <= fire && pred_taken;
      if (fire && pred_taken) begin
        redir_pc_q <= pred_pc;
      end
    end
  end

  assign bus_if.id_valid      = id_valid_q;
  assign bus_if.id_pc         = id_pc_q;
  assign bus_if.id_instr      = id_instr_q;
  assign bus_if.id_pred_taken = id_pred_taken_q;
  assign bus_if.id_pred_pc    = id_pred_pc_q;
  assign bus_if.redir_valid   = redir_valid_q;
  assign bus_if.redir_pc      = redir_pc_q;

`ifdef PREDECODE_STAT_EN
  // ---------------------------------------------------------------------------
  // Statistics: saturating, cleared only by reset (they survive flushes)
  // ---------------------------------------------------------------------------
  logic [STAT_W-1:0] stat_call_q, stat_ret_q, stat_ret_miss_q, stat_drop_q;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + STAT_W'(1) : v;
  endfunction

  // Event counters for calls, returns, empty-RAS returns and wrong-path drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_call_q     <= '0;
      stat_ret_q      <= '0;
      stat_ret_miss_q <= '0;
      stat_drop_q     <= '0;
    end else begin
      stat_call_q     <= sat_inc(stat_call_q,     bus_if.ras_push);
      stat_ret_q      <= sat_inc(stat_ret_q,      bus_if.ras_pop);
      stat_ret_miss_q <= sat_inc(stat_ret_miss_q, fire && is_ret && bus_if.ras_empty);
      stat_drop_q     <= sat_inc(stat_drop_q,     discard);
    end
  end

  assign stat_call_o     = stat_call_q;
  assign stat_ret_o      = stat_ret_q;
  assign stat_ret_miss_o = stat_ret_miss_q;
  assign stat_drop_o     = stat_drop_q;
`else
  // Without statistics the discard strobe has no consumer.
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_jump_predecode.sv
// Testbench for jump_predecode: directed beats with a scoreboard on the id and redirect outputs.
// Expected id/redirect responses are queued by the stimulus and popped by a separate monitor.
// RAS request and ready outputs are checked in the beat cycle itself.
module tb_jump_predecode;
  localparam int W = 64;

  localparam logic [31:0] I_NOP      = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] I_JAL_RA   = 32'h2000_00EF; // jal  x1,+0x200
  localparam logic [31:0] I_RET_RA   = 32'h0000_8067; // jalr x0,0(x1)
  localparam logic [31:0] I_RET_T0   = 32'h0002_8067; // jalr x0,0(x5)
  localparam logic [31:0] I_J_M8     = 32'hFF9F_F06F; // jal  x0,-8
  localparam logic [31:0] I_CALLR_T0 = 32'h0002_80E7; // jalr x1,0(x5)

  typedef struct {
    logic [W-1:0] pc;
    logic [31:0]  instr;
    logic         taken;
    logic [W-1:0] ppc;
  } id_exp_t;

  typedef struct {
    logic [W-1:0] pc;
    int           cyc;
  } redir_exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  id_exp_t    idq[$];
  redir_exp_t rq[$];

  // values sampled mid-cycle by the beat task
  logic         s_ready, s_push, s_pop, s_idv, s_redir;
  logic [W-1:0] s_addr, s_idpc;
  int           npush;

  jump_predecode_if #(.WIDTH(W)) bus ();

`ifdef PREDECODE_STAT_EN
  logic [31:0] st_call, st_ret, st_miss, st_drop;
`endif

  jump_predecode #(.WIDTH(W), .STAT_W(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus_if  (bus)
`ifdef PREDECODE_STAT_EN
    ,
    .stat_call_o     (st_call),
    .stat_ret_o      (st_ret),
    .stat_ret_miss_o (st_miss),
    .stat_drop_o     (st_drop)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Present one cycle of inputs, sample outputs at the falling edge, return just after the rising edge.
  task automatic beat(input logic v, input logic [W-1:0] pc, input logic [31:0] ins,
                      input logic [W-1:0] top, input logic emp, input logic idr, input logic fl);
    bus.if_valid  = v;
    bus.if_pc     = pc;
    bus.if_instr  = ins;
    bus.ras_top   = top;
    bus.ras_empty = emp;
    bus.id_ready  = idr;
    flush         = fl;
    @(negedge clk);
    s_ready = bus.if_ready;
    s_push  = bus.ras_push;
    s_pop   = bus.ras_pop;
    s_addr  = bus.ras_addr;
    s_idv   = bus.id_valid;
    s_idpc  = bus.id_pc;
    s_redir = bus.redir_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    beat(1'b0, '0, I_NOP, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic exp_id(input logic [W-1:0] pc, input logic [31:0] ins, input logic tk, input logic [W-1:0] ppc);
    id_exp_t e;
    e.pc = pc; e.instr = ins; e.taken = tk; e.ppc = ppc;
    idq.push_back(e);
  endtask

  // called right after the firing edge, so the pulse is due in the current cycle
  task automatic exp_redir(input logic [W-1:0] pc);
    redir_exp_t e;
    e.pc = pc; e.cyc = cyc;
    rq.push_back(e);
  endtask

  // Monitor: compare every id transfer and every redirect pulse against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.id_valid && bus.id_ready) begin
        if (idq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL id_unexpected: got pc %h with no expected transfer", bus.id_pc);
        end else begin
          id_exp_t e;
          e = idq.pop_front();
          chk("id_pc",    bus.id_pc,                e.pc);
          chk("id_instr", W'(bus.id_instr),         W'(e.instr));
          chk("id_taken", W'(bus.id_pred_taken),    W'(e.taken));
          chk("id_ppc",   bus.id_pred_pc,           e.ppc);
        end
      end
      if (bus.redir_valid) begin
        if (rq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL redir_unexpected: got pc %h with no expected redirect", bus.redir_pc);
        end else begin
          redir_exp_t r;
          r = rq.pop_front();
          chk("redir_pc",  bus.redir_pc, r.pc);
          chk("redir_cyc", W'(cyc),      W'(r.cyc));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_instr = I_NOP;
    bus.ras_top = '0; bus.ras_empty = 1'b1; bus.id_ready = 1'b1;

    // reset
    idle();
    idle();
    chk("ready_in_reset", W'(s_ready), 0);
    rst = 1'b0;
    idle();
    chk("rst_id_valid", W'(s_idv), 0);
    chk("rst_redir",    W'(s_redir), 0);
    chk("rst_id_pc",    s_idpc, 0);
    chk("rst_push",     W'(s_push), 0);
    chk("rst_ready",    W'(s_ready), 1);

    // call: jal x1,+0x200 at 0x1000
    beat(1'b1, 64'h1000, I_JAL_RA, '0, 1'b1, 1'b1, 1'b0);
    chk("call_push", W'(s_push), 1);
    chk("call_pop",  W'(s_pop), 0);
    chk("call_addr", s_addr, 64'h1000);
    exp_id(64'h1000, I_JAL_RA, 1'b1, 64'h1200);
    exp_redir(64'h1200);

    // wrong-path beats are swallowed
    beat(1'b1, 64'h1004, I_NOP, '0, 1'b1, 1'b1, 1'b0);
    chk("drain1_ready", W'(s_ready), 1);
    chk("drain1_push",  W'(s_push), 0);
    beat(1'b1, 64'h1008, I_JAL_RA, '0, 1'b1, 1'b1, 1'b0);
    chk("drain2_ready", W'(s_ready), 1);
    chk("drain2_push",  W'(s_push), 0);
    chk("drain_no_id",  W'(s_idv), 0);

    // target arrives: passed through, back to RUN
    beat(1'b1, 64'h1200, I_NOP, '0, 1'b1, 1'b1, 1'b0);
    chk("target_ready", W'(s_ready), 1);
    exp_id(64'h1200, I_NOP, 1'b0, '0);

    // return with RAS top 0x1004
    beat(1'b1, 64'h1204, I_RET_RA, 64'h1004, 1'b0, 1'b1, 1'b0);
    chk("ret_pop",  W'(s_pop), 1);
    chk("ret_push", W'(s_push), 0);
    exp_id(64'h1204, I_RET_RA, 1'b1, 64'h1004);
    exp_redir(64'h1004);
    beat(1'b1, 64'h1004, I_NOP, '0, 1'b1, 1'b1, 1'b0);
    chk("ret_tgt_ready", W'(s_ready), 1);
    exp_id(64'h1004, I_NOP, 1'b0, '0);

    // stall: decode blocks for 3 cycles while a call waits
    beat(1'b1, 64'h2000, I_NOP, '0, 1'b1, 1'b1, 1'b0);
    exp_id(64'h2000, I_NOP, 1'b0, '0);
    npush = 0;
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 64'h2004, I_JAL_RA, '0, 1'b1, 1'b0, 1'b0);
      chk("stall_ready", W'(s_ready), 0);
      chk("stall_hold",  s_idpc, 64'h2000);
      npush += int'(s_push);
    end
    beat(1'b1, 64'h2004, I_JAL_RA, '0, 1'b1, 1'b1, 1'b0);
    npush += int'(s_push);
    chk("stall_release_push", W'(s_push), 1);
    chk("stall_push_count",   W'(npush), 1);
    exp_id(64'h2004, I_JAL_RA, 1'b1, 64'h2204);
    exp_redir(64'h2204);
    beat(1'b1, 64'h2204, I_NOP, '0, 1'b1, 1'b1, 1'b0);
    exp_id(64'h2204, I_NOP, 1'b0, '0);

    // return with empty RAS: not taken, no pop
    beat(1'b1, 64'h3000, I_RET_T0, 64'hDEAD, 1'b1, 1'b1, 1'b0);
    chk("eret_pop",  W'(s_pop), 0);
    chk("eret_push", W'(s_push), 0);
    exp_id(64'h3000, I_RET_T0, 1'b0, '0);
    idle();

    // flush in the same cycle as a taken call
    beat(1'b1, 64'h4000, I_JAL_RA, '0, 1'b1, 1'b1, 1'b1);
    chk("flush_ready", W'(s_ready), 0);
    chk("flush_push",  W'(s_push), 0);
    idle();
    chk("flush_id_valid", W'(s_idv), 0);
    chk("flush_redir",    W'(s_redir), 0);
    beat(1'b1, 64'h5000, I_NOP, '0, 1'b1, 1'b1, 1'b0);
    chk("post_flush_ready", W'(s_ready), 1);
    exp_id(64'h5000, I_NOP, 1'b0, '0);

    // negative offset wrap: jal x0,-8 at 0x4
    beat(1'b1, 64'h4, I_J_M8, '0, 1'b1, 1'b1, 1'b0);
    chk("neg_push", W'(s_push), 0);
    chk("neg_addr", s_addr, 64'h4);
    exp_id(64'h4, I_J_M8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    exp_redir(64'hFFFF_FFFF_FFFF_FFFC);
    beat(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, I_NOP, '0, 1'b1, 1'b1, 1'b0);
    exp_id(64'hFFFF_FFFF_FFFF_FFFC, I_NOP, 1'b0, '0);

    // indirect call: push only, no prediction
    beat(1'b1, 64'h6000, I_CALLR_T0, 64'h1234, 1'b0, 1'b1, 1'b0);
    chk("callr_push", W'(s_push), 1);
    chk("callr_pop",  W'(s_pop), 0);
    chk("callr_addr", s_addr, 64'h6000);
    exp_id(64'h6000, I_CALLR_T0, 1'b0, '0);

    // flush while draining returns the stage to RUN
    beat(1'b1, 64'h7000, I_JAL_RA, '0, 1'b1, 1'b1, 1'b0);
    exp_id(64'h7000, I_JAL_RA, 1'b1, 64'h7200);
    exp_redir(64'h7200);
    beat(1'b0, '0, I_NOP, '0, 1'b1, 1'b1, 1'b1);
    beat(1'b1, 64'h7004, I_NOP, '0, 1'b1, 1'b1, 1'b0);
    chk("drain_flush_ready", W'(s_ready), 1);
    exp_id(64'h7004, I_NOP, 1'b0, '0);

    idle();
    idle();
    idle();
    chk("id_queue_empty",    W'(idq.size()), 0);
    chk("redir_queue_empty", W'(rq.size()), 0);

`ifdef PREDECODE_STAT_EN
    chk("stat_call", W'(st_call), 4);
    chk("stat_ret",  W'(st_ret), 1);
    chk("stat_miss", W'(st_miss), 1);
    chk("stat_drop", W'(st_drop), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
